// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and its datapath:
// state enum, opcode/funct values, mux selects and the decoded control bundle.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET       = 5'd0,
        ST_FETCH       = 5'd1,
        ST_WAIT        = 5'd2,
        ST_DECODE      = 5'd3,
        ST_R_EXEC      = 5'd4,
        ST_R_WB        = 5'd5,
        ST_ADDI_EXEC   = 5'd6,
        ST_ADDI_WB     = 5'd7,
        ST_MEM_ADDR    = 5'd8,
        ST_MEM_WR      = 5'd9,
        ST_MEM_RD      = 5'd10,
        ST_MEM_RD_WAIT = 5'd11,
        ST_LW_WB       = 5'd12,
        ST_BRANCH      = 5'd13,
        ST_JUMP        = 5'd14,
        ST_EXC         = 5'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] SRCB_B       = 4'd0;
    localparam logic [3:0] SRCB_FOUR    = 4'd1;
    localparam logic [3:0] SRCB_SEXT    = 4'd2;
    localparam logic [3:0] SRCB_SEXT_SH = 4'd3;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_reset;
        logic       instReg_reset;
        logic       a_reset;
        logic       b_reset;
        logic       ALUout_reset;
        logic       pc_load;
        logic       instReg_load;
        logic       a_load;
        logic       b_load;
        logic       ALUout_load;
        logic       mdr_load;
        logic       epc_load;
        logic       mem_write;
        logic       iord;
        logic [1:0] pc_source;
        logic       ALUSrcA;
        logic [3:0] ALUSrcB;
        logic [2:0] ALU_select;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic funct_supported(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_XOR);
    endfunction

    function automatic logic [2:0] alu_sel_from_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control decode. Only the branch load strobe looks
// past the registered state, at the live ALU_zero flag and the held opcode.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] EXC_VECTOR_SEL = 2'd3
) (
    input  state_t     state_i,
    input  logic       cnt_zero_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       alu_zero_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_RESET: begin
                ctrl_o.pc_reset      = 1'b1;
                ctrl_o.instReg_reset = 1'b1;
                ctrl_o.a_reset       = 1'b1;
                ctrl_o.b_reset       = 1'b1;
                ctrl_o.ALUout_reset  = 1'b1;
            end
            ST_FETCH: begin
                ctrl_o.ALUSrcB    = SRCB_FOUR;
                ctrl_o.ALU_select = ALU_ADD;
            end
            ST_WAIT: begin
                // PC+4 is still on the ALU output when the fetch completes
                ctrl_o.ALUSrcB      = SRCB_FOUR;
                ctrl_o.ALU_select   = ALU_ADD;
                ctrl_o.instReg_load = cnt_zero_i;
                ctrl_o.pc_load      = cnt_zero_i;
                ctrl_o.pc_source    = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl_o.a_load      = 1'b1;
                ctrl_o.b_load      = 1'b1;
                ctrl_o.ALUout_load = 1'b1;
                ctrl_o.ALUSrcB     = SRCB_SEXT_SH;
                ctrl_o.ALU_select  = ALU_ADD;
            end
            ST_R_EXEC: begin
                ctrl_o.ALUSrcA     = 1'b1;
                ctrl_o.ALUSrcB     = SRCB_B;
                ctrl_o.ALU_select  = alu_sel_from_funct(funct_i);
                ctrl_o.ALUout_load = 1'b1;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_ADDI_EXEC, ST_MEM_ADDR: begin
                ctrl_o.ALUSrcA     = 1'b1;
                ctrl_o.ALUSrcB     = SRCB_SEXT;
                ctrl_o.ALU_select  = ALU_ADD;
                ctrl_o.ALUout_load = 1'b1;
            end
            ST_ADDI_WB: ctrl_o.reg_write = 1'b1;
            ST_MEM_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_MEM_RD: ctrl_o.iord = 1'b1;
            ST_MEM_RD_WAIT: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mdr_load = cnt_zero_i;
            end
            ST_LW_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.ALUSrcA    = 1'b1;
                ctrl_o.ALUSrcB    = SRCB_B;
                ctrl_o.ALU_select = ALU_SUB;
                ctrl_o.pc_source  = PCSRC_ALUOUT;
                ctrl_o.pc_load    = (op_i == OP_BNE) ? !alu_zero_i : alu_zero_i;
            end
            ST_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.pc_load   = 1'b1;
            end
            ST_EXC: begin
                ctrl_o.epc_load  = 1'b1;
                ctrl_o.pc_source = EXC_VECTOR_SEL;
                ctrl_o.pc_load   = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM (Moore). Optional macro CTRL_OVF_EXC_EN routes
// add/sub/addi overflow to the exception state instead of writeback.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int         MEM_WAIT       = 1,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'd3
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] Operation,
    input  logic [5:0] Funct,
    input  logic       ALU_zero,
    input  logic       ALU_overflow,
    output logic       pc_reset,
    output logic       instReg_reset,
    output logic       a_reset,
    output logic       b_reset,
    output logic       ALUout_reset,
    output logic       pc_load,
    output logic       instReg_load,
    output logic       a_load,
    output logic       b_load,
    output logic       ALUout_load,
    output logic       mdr_load,
    output logic       epc_load,
    output logic       mem_write,
    output logic       iord,
    output logic [1:0] pc_source,
    output logic       ALUSrcA,
    output logic [3:0] ALUSrcB,
    output logic [2:0] ALU_select,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [4:0] state_dbg
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ovf_trap;
    ctrl_t      ctrl;

`ifdef CTRL_OVF_EXC_EN
    assign ovf_trap = ALU_overflow;
`else
    logic unused_ovf;
    assign unused_ovf = ALU_overflow;
    assign ovf_trap   = 1'b0;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                cnt_d   = WAIT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_DECODE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_DECODE: begin
                case (Operation)
                    OP_RTYPE:     state_d = funct_supported(Funct) ? ST_R_EXEC : ST_EXC;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_EXC;
                endcase
            end
            // Only add/sub trap on overflow; and/xor cannot overflow
            ST_R_EXEC: state_d = (ovf_trap && (Funct == FN_ADD || Funct == FN_SUB))
                                 ? ST_EXC : ST_R_WB;
            ST_ADDI_EXEC: state_d = ovf_trap ? ST_EXC : ST_ADDI_WB;
            ST_MEM_ADDR:  state_d = (Operation == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                cnt_d   = WAIT_INIT;
                state_d = ST_MEM_RD_WAIT;
            end
            ST_MEM_RD_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_LW_WB;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_R_WB, ST_ADDI_WB, ST_MEM_WR, ST_LW_WB,
            ST_BRANCH, ST_JUMP, ST_EXC: state_d = ST_FETCH;
            default: state_d = ST_RESET;
        endcase
    end

    mc_ctrl_decode #(
        .EXC_VECTOR_SEL(EXC_VECTOR_SEL)
    ) u_decode (
        .state_i    (state_q),
        .cnt_zero_i (cnt_q == 2'd0),
        .op_i       (Operation),
        .funct_i    (Funct),
        .alu_zero_i (ALU_zero),
        .ctrl_o     (ctrl)
    );

    assign pc_reset      = ctrl.pc_reset;
    assign instReg_reset = ctrl.instReg_reset;
    assign a_reset       = ctrl.a_reset;
    assign b_reset       = ctrl.b_reset;
    assign ALUout_reset  = ctrl.ALUout_reset;
    assign pc_load       = ctrl.pc_load;
    assign instReg_load  = ctrl.instReg_load;
    assign a_load        = ctrl.a_load;
    assign b_load        = ctrl.b_load;
    assign ALUout_load   = ctrl.ALUout_load;
    assign mdr_load      = ctrl.mdr_load;
    assign epc_load      = ctrl.epc_load;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign pc_source     = ctrl.pc_source;
    assign ALUSrcA       = ctrl.ALUSrcA;
    assign ALUSrcB       = ctrl.ALUSrcB;
    assign ALU_select    = ctrl.ALU_select;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: instance a at MEM_WAIT=1, instance b at
// MEM_WAIT=2, both driven by the same clock, reset and instruction fields.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Operation = 6'h00;
    logic [5:0] Funct = 6'h20;
    logic       ALU_zero = 1'b0;
    logic       ALU_overflow = 1'b0;

    logic       a_pc_reset, a_instReg_reset, a_a_reset, a_b_reset, a_ALUout_reset;
    logic       a_pc_load, a_instReg_load, a_a_load, a_b_load, a_ALUout_load;
    logic       a_mdr_load, a_epc_load, a_mem_write, a_iord, a_ALUSrcA;
    logic [1:0] a_pc_source;
    logic [3:0] a_ALUSrcB;
    logic [2:0] a_ALU_select;
    logic       a_reg_write, a_reg_dst, a_mem_to_reg;
    logic [4:0] a_state;

    logic       b_pc_reset, b_instReg_reset, b_a_reset, b_b_reset, b_ALUout_reset;
    logic       b_pc_load, b_instReg_load, b_a_load, b_b_load, b_ALUout_load;
    logic       b_mdr_load, b_epc_load, b_mem_write, b_iord, b_ALUSrcA;
    logic [1:0] b_pc_source;
    logic [3:0] b_ALUSrcB;
    logic [2:0] b_ALU_select;
    logic       b_reg_write, b_reg_dst, b_mem_to_reg;
    logic [4:0] b_state;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mc_control_unit #(.MEM_WAIT(1), .EXC_VECTOR_SEL(2'd3)) dut_a (
        .Clk(Clk), .reset(reset), .Operation(Operation), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .pc_reset(a_pc_reset), .instReg_reset(a_instReg_reset), .a_reset(a_a_reset),
        .b_reset(a_b_reset), .ALUout_reset(a_ALUout_reset), .pc_load(a_pc_load),
        .instReg_load(a_instReg_load), .a_load(a_a_load), .b_load(a_b_load),
        .ALUout_load(a_ALUout_load), .mdr_load(a_mdr_load), .epc_load(a_epc_load),
        .mem_write(a_mem_write), .iord(a_iord), .pc_source(a_pc_source),
        .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALU_select(a_ALU_select),
        .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .state_dbg(a_state)
    );

    mc_control_unit #(.MEM_WAIT(2), .EXC_VECTOR_SEL(2'd3)) dut_b (
        .Clk(Clk), .reset(reset), .Operation(Operation), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .pc_reset(b_pc_reset), .instReg_reset(b_instReg_reset), .a_reset(b_a_reset),
        .b_reset(b_b_reset), .ALUout_reset(b_ALUout_reset), .pc_load(b_pc_load),
        .instReg_load(b_instReg_load), .a_load(b_a_load), .b_load(b_b_load),
        .ALUout_load(b_ALUout_load), .mdr_load(b_mdr_load), .epc_load(b_epc_load),
        .mem_write(b_mem_write), .iord(b_iord), .pc_source(b_pc_source),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALU_select(b_ALU_select),
        .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .state_dbg(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset pulse ending at a negedge; the following posedge enters FETCH.
    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic ovf);
        @(negedge Clk);
        Operation    = op;
        Funct        = fn;
        ALU_zero     = z;
        ALU_overflow = ovf;
        reset        = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        tick();
    endtask

    int mdr_pulses;
    logic any_mem_write;

    initial begin
        // Reset asserted mid-cycle takes effect without a clock edge
        @(posedge Clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_state_async", a_state, ST_RESET);
        chk("rst_resets_on", {a_pc_reset, a_instReg_reset, a_a_reset, a_b_reset, a_ALUout_reset}, 5'b11111);
        chk("rst_loads_off", {a_pc_load, a_instReg_load, a_mem_write, a_reg_write, a_epc_load}, 5'b00000);
        @(negedge Clk);
        reset = 1'b0;
        #1;
        chk("rst_held_after_release", a_state, ST_RESET);
        tick();
        chk("rst_then_fetch", a_state, ST_FETCH);
        chk("fetch_resets_off", {a_pc_reset, a_instReg_reset, a_a_reset, a_b_reset, a_ALUout_reset}, 5'b00000);

        // R-type add: FETCH WAIT DECODE R_EXEC R_WB FETCH
        start_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        chk("add_c1_fetch_sel", {a_iord, a_ALUSrcA, a_ALUSrcB, a_ALU_select}, {1'b0, 1'b0, 4'd1, 3'b001});
        tick();
        chk("add_c2_state", a_state, ST_WAIT);
        chk("add_c2_ir_pc_load", {a_instReg_load, a_pc_load, a_pc_source}, {1'b1, 1'b1, 2'd0});
        tick();
        chk("add_c3_decode", {a_state, a_a_load, a_b_load, a_ALUout_load, a_ALUSrcB}, {ST_DECODE, 1'b1, 1'b1, 1'b1, 4'd3});
        tick();
        chk("add_c4_exec", {a_state, a_ALUSrcA, a_ALUSrcB, a_ALU_select, a_reg_write}, {ST_R_EXEC, 1'b1, 4'd0, 3'b001, 1'b0});
        tick();
        chk("add_c5_wb", {a_state, a_reg_write, a_reg_dst, a_mem_to_reg}, {ST_R_WB, 1'b1, 1'b1, 1'b0});
        tick();
        chk("add_c6_fetch", {a_state, a_reg_write}, {ST_FETCH, 1'b0});

        // R-type sub and xor select the matching ALU op
        start_instr(OP_RTYPE, FN_SUB, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("sub_alu_sel", {a_state, a_ALU_select}, {ST_R_EXEC, 3'b010});
        start_instr(OP_RTYPE, FN_XOR, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("xor_alu_sel", {a_state, a_ALU_select}, {ST_R_EXEC, 3'b100});

        // lw at MEM_WAIT=2 (instance b): 9 cycles, mdr on 2nd wait cycle
        start_instr(OP_LW, 6'h00, 1'b0, 1'b0);
        mdr_pulses    = 0;
        any_mem_write = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (b_mdr_load) mdr_pulses++;
            any_mem_write = any_mem_write | b_mem_write;
            if (c == 2) chk("lwb_c2_ir_not_yet", b_instReg_load, 1'b0);
            if (c == 3) chk("lwb_c3_ir_load", {b_state, b_instReg_load}, {ST_WAIT, 1'b1});
            if (c == 7) chk("lwb_c7_wait1", {b_state, b_iord, b_mdr_load}, {ST_MEM_RD_WAIT, 1'b1, 1'b0});
            if (c == 8) chk("lwb_c8_mdr", {b_state, b_iord, b_mdr_load}, {ST_MEM_RD_WAIT, 1'b1, 1'b1});
            if (c == 9) chk("lwb_c9_wb", {b_state, b_reg_write, b_reg_dst, b_mem_to_reg}, {ST_LW_WB, 1'b1, 1'b0, 1'b1});
            tick();
        end
        chk("lwb_back_fetch", b_state, ST_FETCH);
        chk("lwb_mdr_once", mdr_pulses, 1);
        chk("lwb_no_mem_write", any_mem_write, 1'b0);

        // lw at MEM_WAIT=1 (instance a) completes in 7 cycles
        start_instr(OP_LW, 6'h00, 1'b0, 1'b0);
        repeat (5) tick();
        chk("lwa_c6_mdr", {a_state, a_mdr_load}, {ST_MEM_RD_WAIT, 1'b1});
        tick(); tick();
        chk("lwa_c8_fetch", a_state, ST_FETCH);

        // sw: one-cycle mem_write, 5 cycles total
        start_instr(OP_SW, 6'h00, 1'b0, 1'b0);
        repeat (4) tick();
        chk("sw_c5_write", {a_state, a_iord, a_mem_write, a_reg_write}, {ST_MEM_WR, 1'b1, 1'b1, 1'b0});
        tick();
        chk("sw_c6_fetch", {a_state, a_mem_write}, {ST_FETCH, 1'b0});

        // beq taken, bne not taken / taken
        start_instr(OP_BEQ, 6'h00, 1'b1, 1'b0);
        repeat (3) tick();
        chk("beq_z1", {a_state, a_pc_load, a_pc_source, a_ALU_select}, {ST_BRANCH, 1'b1, 2'd1, 3'b010});
        tick();
        chk("beq_c5_fetch", a_state, ST_FETCH);
        start_instr(OP_BNE, 6'h00, 1'b1, 1'b0);
        repeat (3) tick();
        chk("bne_z1", {a_state, a_pc_load}, {ST_BRANCH, 1'b0});
        ALU_zero = 1'b0;
        #1;
        chk("bne_z0", a_pc_load, 1'b1);

        // jump
        start_instr(OP_J, 6'h00, 1'b0, 1'b0);
        repeat (3) tick();
        chk("j_c4", {a_state, a_pc_load, a_pc_source}, {ST_JUMP, 1'b1, 2'd2});

        // illegal opcode and unsupported funct both trap
        start_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        repeat (3) tick();
        chk("exc_op", {a_state, a_epc_load, a_pc_load, a_pc_source, a_reg_write}, {ST_EXC, 1'b1, 1'b1, 2'd3, 1'b0});
        tick();
        chk("exc_op_fetch", a_state, ST_FETCH);
        start_instr(OP_RTYPE, 6'h00, 1'b0, 1'b0);
        repeat (3) tick();
        chk("exc_funct", {a_state, a_epc_load, a_pc_source, a_reg_write}, {ST_EXC, 1'b1, 2'd3, 1'b0});

        // addi with overflow flagged during ADDI_EXEC
        start_instr(OP_ADDI, 6'h00, 1'b0, 1'b1);
        repeat (3) tick();
        chk("addi_exec", {a_state, a_ALUSrcA, a_ALUSrcB, a_ALU_select}, {ST_ADDI_EXEC, 1'b1, 4'd2, 3'b001});
        tick();
`ifdef CTRL_OVF_EXC_EN
        chk("addi_ovf_trap", {a_state, a_reg_write, a_epc_load}, {ST_EXC, 1'b0, 1'b1});
`else
        chk("addi_ovf_ignored", {a_state, a_reg_write, a_reg_dst}, {ST_ADDI_WB, 1'b1, 1'b0});
`endif

        // reset mid-instruction aborts immediately
        start_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midinstr_reset", {a_state, a_reg_write, a_mem_write, a_pc_reset}, {ST_RESET, 1'b0, 1'b0, 1'b1});
        @(negedge Clk);
        reset = 1'b0;
        tick();
        chk("midinstr_refetch", a_state, ST_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
